uart_strobe: RTL and testbench

//  Bus-cycle sequencer between the 6502 bus and the SC28L92 DUART (Intel/80xxx mode, uart_im=1).

---
 rtl/uart_strobe.sv | 148 ++++++++++++++
 tb/tb_uart_strobe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_strobe.sv
// 6502 <-> SC28L92 bus-cycle sequencer: timed rd/wr strobes, RDY stretching, IRQ conditioning.
// Build option: define UART_IRQ_SYNC_EN for a 2-flop irq synchronizer (default: single register).
module uart_strobe #(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic phi2,
    input  logic uart_cs,
    input  logic rw,
    input  logic uart_irq,
    output logic uart_rdn,
    output logic uart_wrn,
    output logic ready,
    output logic irq,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] REC_LD    = 8'(RECOVERY_CYC);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] rec, rec_nx;
    logic       dir, dir_nx, pend, pend_nx, rel_pend, rel_pend_nx, phi2_q;
    logic       rdn_nx, wrn_nx, ready_nx, busy_nx, done, accept;

    // A phi2 rise while the CPU is stalled is the same access being held, so only a
    // released (ready=1) bus may start a new one.
    assign accept = phi2 & ~phi2_q & ~uart_cs & ready;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rec_nx      = rec;
        dir_nx      = dir;
        pend_nx     = pend;
        rel_pend_nx = rel_pend;
        ready_nx    = ready;
        done        = 1'b0;
        if (rel_pend && !phi2) begin
            ready_nx    = 1'b1;
            rel_pend_nx = 1'b0;
        end
        case (state)
            IDLE: if (accept) begin
                state_nx = SETUP;
                cnt_nx   = SETUP_LD;
                dir_nx   = rw;
                ready_nx = 1'b0;
            end
            SETUP: if (cnt == '0) begin
                state_nx = STROBE;
                cnt_nx   = STROBE_LD;
            end else cnt_nx = cnt - 4'd1;
            STROBE: if (cnt == '0) begin
                if (HOLD_CYC == 0) done = 1'b1;
                else begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end
            end else cnt_nx = cnt - 4'd1;
            HOLD: if (cnt == '0) done = 1'b1;
                  else cnt_nx = cnt - 4'd1;
            RECOVER: begin
                if (accept) begin
                    pend_nx  = 1'b1;
                    dir_nx   = rw;
                    ready_nx = 1'b0;
                end
                // A start coinciding with recovery expiry goes straight to SETUP.
                if (rec == '0) begin
                    if (pend || accept) begin
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                        pend_nx  = 1'b0;
                    end else state_nx = IDLE;
                end else rec_nx = rec - 8'd1;
            end
            default: state_nx = IDLE;
        endcase
        if (done) begin
            if (RECOVERY_CYC == 0) state_nx = IDLE;
            else begin
                state_nx = RECOVER;
                rec_nx   = REC_LD;
            end
            // RDY may only rise during phi2 low; otherwise wait for the falling edge.
            if (phi2) rel_pend_nx = 1'b1;
            else      ready_nx    = 1'b1;
        end
        rdn_nx  = !(state_nx == STROBE && dir_nx);
        wrn_nx  = !(state_nx == STROBE && !dir_nx);
        busy_nx = (state_nx != IDLE) || pend_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rec      <= '0;
            dir      <= 1'b0;
            pend     <= 1'b0;
            rel_pend <= 1'b0;
            phi2_q   <= 1'b0;
            uart_rdn <= 1'b1;
            uart_wrn <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rec      <= rec_nx;
            dir      <= dir_nx;
            pend     <= pend_nx;
            rel_pend <= rel_pend_nx;
            phi2_q   <= phi2;
            uart_rdn <= rdn_nx;
            uart_wrn <= wrn_nx;
            ready    <= ready_nx;
            busy     <= busy_nx;
        end
    end

`ifdef UART_IRQ_SYNC_EN
    logic irq_s1;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1 <= 1'b1;
            irq    <= 1'b1;
        end else begin
            irq_s1 <= uart_irq;
            irq    <= irq_s1;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq <= 1'b1;
        else          irq <= uart_irq;
    end
`endif
endmodule

// File: tb/tb_uart_strobe.sv
// Directed bench for uart_strobe: strobe scoreboard for the default instance, inline checks
// for a zero-hold/zero-recovery instance, reset, RDY release and irq latency.
module tb_uart_strobe;
    logic clock = 1'b0, reset_n = 1'b0, phi2 = 1'b0, rw = 1'b1, uart_irq = 1'b1;
    logic cs_a = 1'b1, cs_b = 1'b1;
    logic rdn_a, wrn_a, ready_a, irq_a, busy_a;
    logic rdn_b, wrn_b, ready_b, irq_b, busy_b;
    int   cyc = 0, half = 4, pcnt = 0;
    int   checks = 0, failures = 0;

`ifdef UART_IRQ_SYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 1;
`endif

    typedef struct {logic wr; int min_fall; int max_fall; int len;} exp_t;
    exp_t sbq[$];

    uart_strobe dut_a (
        .clock(clock), .reset_n(reset_n), .phi2(phi2), .uart_cs(cs_a), .rw(rw),
        .uart_irq(uart_irq), .uart_rdn(rdn_a), .uart_wrn(wrn_a), .ready(ready_a),
        .irq(irq_a), .busy(busy_a));

    uart_strobe #(.HOLD_CYC(0), .RECOVERY_CYC(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .phi2(phi2), .uart_cs(cs_b), .rw(rw),
        .uart_irq(uart_irq), .uart_rdn(rdn_b), .uart_wrn(wrn_b), .ready(ready_b),
        .irq(irq_b), .busy(busy_b));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // phi2 is a divided copy of clock, changing just after the rising edge.
    always @(posedge clock) begin
        #1;
        if (pcnt >= half - 1) begin
            pcnt = 0;
            phi2 = ~phi2;
        end else pcnt = pcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor for dut_a: measures each strobe and checks it against the scoreboard.
    int m_in = 0, m_wr = 0, m_fall = 0, m_len = 0;
    always @(negedge clock) begin
        if (!reset_n) m_in = 0;
        else begin
            if (!rdn_a || !wrn_a) chk("strobe_excl", {rdn_a, wrn_a} != 2'b00, 1);
            if (!m_in && (!rdn_a || !wrn_a)) begin
                m_in = 1; m_wr = int'(!wrn_a); m_fall = cyc; m_len = 1;
            end else if (m_in && (!rdn_a || !wrn_a)) m_len++;
            else if (m_in) begin
                exp_t e;
                m_in = 0;
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("strobe_dir", m_wr, e.wr);
                    chk("strobe_fall_min", m_fall >= e.min_fall, 1);
                    chk("strobe_fall_max", m_fall <= e.max_fall, 1);
                    chk("strobe_len", m_len, e.len);
                end
            end
        end
    end

    // Drive a select into the next phi2 rise; sc is the cycle at which the start is registered.
    task automatic start_acc(input logic is_b, input logic rw_v, output int sc);
        @(negedge clock);
        while (phi2) @(negedge clock);
        rw = rw_v;
        if (is_b) cs_b = 1'b0; else cs_a = 1'b0;
        @(negedge clock);
        while (!phi2) @(negedge clock);
        sc = cyc + 1;
        @(negedge clock);
        cs_a = 1'b1;
        cs_b = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy_a === 1'b0 && ready_a === 1'b1) break;
        end
        chk(tag, {busy_a, ready_a}, 2'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, sc2, n;
        exp_t e;
        repeat (3) @(negedge clock);
        chk("rst_rdn", rdn_a, 1); chk("rst_wrn", wrn_a, 1); chk("rst_ready", ready_a, 1);
        chk("rst_irq", irq_a, 1); chk("rst_busy", busy_a, 0);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // async reset in the middle of a read strobe
        start_acc(1'b0, 1'b1, sc);
        e = '{1'b0, sc + 2, sc + 2, 3}; sbq.push_back(e);
        while (cyc < sc + 3) @(negedge clock);
        chk("mid_strobe_rdn", rdn_a, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rdn", rdn_a, 1); chk("async_wrn", wrn_a, 1);
        chk("async_ready", ready_a, 1); chk("async_busy", busy_a, 0);
        sbq.delete();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_rst_idle", {busy_a, ready_a, rdn_a, wrn_a}, 4'b0111);

        // read with defaults: rdn low 3 cycles from start+2, ready back at start+6 (phi2 low)
        start_acc(1'b0, 1'b1, sc);
        e = '{1'b0, sc + 2, sc + 2, 3}; sbq.push_back(e);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("rd_ready_k%0d", k), ready_a, (k <= 5) ? 0 : 1);
            chk($sformatf("rd_busy_k%0d", k), busy_a, 1);
        end
        wait_idle("rd_idle");

        // write; rw flipped right after start must not matter
        start_acc(1'b0, 1'b0, sc);
        e = '{1'b1, sc + 2, sc + 2, 3}; sbq.push_back(e);
        rw = 1'b1;
        wait_idle("wr_idle");

        // back-to-back: second start lands two cycles into RECOVER and is held pending
        start_acc(1'b0, 1'b1, sc);
        e = '{1'b0, sc + 2, sc + 2, 3}; sbq.push_back(e);
        start_acc(1'b0, 1'b0, sc2);
        e = '{1'b1, sc + 6 + 8, sc + 6 + 8 + 8, 3}; sbq.push_back(e);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("b2b_ready_k%0d", k), ready_a, 0);
            chk($sformatf("b2b_busy_k%0d", k), busy_a, 1);
        end
        n = 0;
        while (ready_a !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        chk("b2b_ready_rel", ready_a, 1);
        chk("b2b_sb_drained", sbq.size(), 0);
        wait_idle("b2b_idle");

        // HOLD ends with phi2 high: release deferred to the phi2 falling edge
        half = 3;
        repeat (8) @(negedge clock);
        start_acc(1'b0, 1'b1, sc);
        e = '{1'b0, sc + 2, sc + 2, 3}; sbq.push_back(e);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("defer_ready_k%0d", k), ready_a, (k <= 8) ? 0 : 1);
        end
        wait_idle("defer_idle");
        half = 4;
        repeat (10) @(negedge clock);

        // zero hold / zero recovery instance: two accesses, no recovery gap
        for (int a = 0; a < 2; a++) begin
            start_acc(1'b1, a == 0, sc);
            for (int k = 0; k <= 6; k++) begin
                if (k > 0) @(negedge clock);
                chk($sformatf("b%0d_act_k%0d", a, k), (a == 0) ? rdn_b : wrn_b,
                    (k >= 2 && k <= 4) ? 0 : 1);
                chk($sformatf("b%0d_idle_k%0d", a, k), (a == 0) ? wrn_b : rdn_b, 1);
                chk($sformatf("b%0d_ready_k%0d", a, k), ready_b, (k <= 4) ? 0 : 1);
                chk($sformatf("b%0d_busy_k%0d", a, k), busy_b, (k <= 4) ? 1 : 0);
            end
        end

        // irq: 5-cycle low pulse, delayed by the build's latency
        @(negedge clock);
        uart_irq = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            chk($sformatf("irq_k%0d", k), irq_a, (k >= IRQ_LAT && k <= IRQ_LAT + 4) ? 0 : 1);
            if (k == 5) uart_irq = 1'b1;
        end

        repeat (3) @(negedge clock);
        chk("sb_empty_end", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
